// File: rtl/fetch_sequencer_pkg.sv
// Shared definitions for the fetch sequencer: FSM state encoding and the
// Controller's opcode constants so RTL and bench decode instructions alike.
package fetch_sequencer_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_FETCH  = 3'd1,
      ST_HOLD   = 3'd2,
      ST_EXEC   = 3'd3,
      ST_HALTED = 3'd4
   } state_t;

   localparam int OPCODE_W = 4;

   localparam logic [OPCODE_W-1:0] OP_NOP     = 4'b0000;
   localparam logic [OPCODE_W-1:0] OP_JMP_REG = 4'b1000;
   localparam logic [OPCODE_W-1:0] OP_JMP_IMM = 4'b1001;
   localparam logic [OPCODE_W-1:0] OP_HALT    = 4'b1111;

   // Opcode sits in the top nibble of an 8-bit instruction word.
   function automatic logic [OPCODE_W-1:0] opcode_of(input logic [7:0] word);
      return word[7:4];
   endfunction

endpackage

// File: rtl/fetch_sequencer_pc_register.sv
// Program counter register: applies load (jump) over increment when enabled,
// with zero-extended immediate targets and natural wrap on increment.
module fetch_sequencer_pc_register #(
   parameter int              PC_W     = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            en,
   input  logic            inc,
   input  logic            load,
   input  logic            sel,
   input  logic [PC_W-1:0] jump_reg,
   input  logic [3:0]      jump_imm,
   output logic [PC_W-1:0] pc
);

   logic [PC_W-1:0] pc_next;
   logic [PC_W-1:0] imm_target;

   assign imm_target = {{(PC_W-4){1'b0}}, jump_imm};

   always_comb begin
      pc_next = pc;
      if (en) begin
         if (load) begin
            pc_next = sel ? imm_target : jump_reg;
         end else if (inc) begin
            pc_next = pc + PC_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc <= RESET_PC;
      end else begin
         pc <= pc_next;
      end
   end

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: owns the PC, fetches over an imem req/ack handshake with a
// timeout, hands instructions to the Controller and applies its PC commands.
module fetch_sequencer
   import fetch_sequencer_pkg::*;
#(
   parameter int              PC_W     = 8,
   parameter int              INSTR_W  = 8,
   parameter logic [PC_W-1:0] RESET_PC = '0,
   parameter int              MAX_WAIT = 15
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               start,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic               imem_ack,
   input  logic [INSTR_W-1:0] imem_data,
   output logic [INSTR_W-1:0] instr,
   output logic               instr_valid,
   input  logic               instr_ready,
   input  logic               inc_pc,
   input  logic               load_pc,
   input  logic               sel_pc,
   input  logic [PC_W-1:0]    jump_reg,
   input  logic [3:0]         jump_imm,
   input  logic               halt_req,
   output logic [PC_W-1:0]    pc,
   output logic               halted,
   output logic               fetch_err
);

   localparam int              CNT_W     = $clog2(MAX_WAIT + 1);
   localparam logic [CNT_W-1:0] WAIT_LAST = CNT_W'(MAX_WAIT - 1);

   state_t           state;
   logic [CNT_W-1:0] wait_cnt;
   logic             in_exec;
   logic             pc_en;
   logic             pc_cmd;

   assign in_exec = (state == ST_EXEC);
   // halt_req outranks every PC command, so it simply masks the PC update.
   assign pc_en   = in_exec && !halt_req;
   assign pc_cmd  = load_pc || inc_pc;

   fetch_sequencer_pc_register #(
      .PC_W     (PC_W),
      .RESET_PC (RESET_PC)
   ) u_pc_register (
      .clk      (clk),
      .reset    (reset),
      .en       (pc_en),
      .inc      (inc_pc),
      .load     (load_pc),
      .sel      (sel_pc),
      .jump_reg (jump_reg),
      .jump_imm (jump_imm),
      .pc       (pc)
   );

   assign imem_addr = pc;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= ST_IDLE;
         wait_cnt    <= '0;
         instr       <= '0;
         imem_req    <= 1'b0;
         instr_valid <= 1'b0;
         halted      <= 1'b0;
         fetch_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start) begin
                  state    <= ST_FETCH;
                  imem_req <= 1'b1;
                  wait_cnt <= '0;
               end
            end

            ST_FETCH: begin
               if (imem_ack) begin
                  instr       <= imem_data;
                  wait_cnt    <= '0;
                  imem_req    <= 1'b0;
                  instr_valid <= 1'b1;
                  state       <= ST_HOLD;
               end else if (wait_cnt == WAIT_LAST) begin
                  // This is the MAX_WAIT-th unacknowledged cycle: give up.
                  fetch_err <= 1'b1;
                  imem_req  <= 1'b0;
                  halted    <= 1'b1;
                  state     <= ST_HALTED;
               end else begin
                  wait_cnt <= wait_cnt + CNT_W'(1);
               end
            end

            ST_HOLD: begin
               if (instr_ready) begin
                  instr_valid <= 1'b0;
                  state       <= ST_EXEC;
               end
            end

            ST_EXEC: begin
               if (halt_req) begin
                  halted <= 1'b1;
                  state  <= ST_HALTED;
               end else if (pc_cmd) begin
                  imem_req <= 1'b1;
                  wait_cnt <= '0;
                  state    <= ST_FETCH;
               end
            end

            ST_HALTED: begin
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
               halted      <= 1'b1;
            end

            default: begin
               state       <= ST_IDLE;
               imem_req    <= 1'b0;
               instr_valid <= 1'b0;
               wait_cnt    <= '0;
            end
         endcase
      end
   end

endmodule
